// File: rtl/identity_chk_pkg.sv
// rtl/identity_chk_pkg.sv - shared widths, MISR constants, FSM states and the response fold
package identity_chk_pkg;

    localparam int Y_W   = 127;
    localparam int CNT_W = 16;
    localparam int SIG_W = 32;

    localparam logic [SIG_W-1:0] POLY = 32'h04C1_1DB7;
    localparam logic [SIG_W-1:0] SEED = 32'hFFFF_FFFF;

    // Response width rounded up to whole signature words (127 -> 128)
    localparam int FOLD_W = ((Y_W + SIG_W - 1) / SIG_W) * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SIG_W-1:0] fold(input logic [Y_W-1:0] data);
        logic [FOLD_W-1:0] ext;
        logic [SIG_W-1:0]  acc;
        ext = FOLD_W'(data);
        acc = '0;
        for (int i = 0; i < FOLD_W / SIG_W; i++) begin
            acc = acc ^ ext[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/identity_resp_checker_if.sv
// rtl/identity_resp_checker_if.sv - run control, response buses and result bundle of the checker
interface identity_resp_checker_if;
    import identity_chk_pkg::*;

    logic             start;
    logic [CNT_W-1:0] run_len;
    logic             y_valid;
    logic [Y_W-1:0]   y_ref;
    logic [Y_W-1:0]   y_dut;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_mis_idx;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, run_len, y_valid, y_ref, y_dut,
        input  busy, done, pass, mismatch_cnt, first_mis_idx, signature
    );

    modport slave (
        input  start, run_len, y_valid, y_ref, y_dut,
        output busy, done, pass, mismatch_cnt, first_mis_idx, signature
    );

endinterface

// File: rtl/identity_misr.sv
// rtl/identity_misr.sv - MISR compacting folded reference responses into a signature
module identity_misr
    import identity_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [Y_W-1:0]   data,
    output logic [SIG_W-1:0] signature
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= SEED;
        end else if (clr) begin
            signature <= SEED;
        end else if (en) begin
            signature <= {signature[SIG_W-2:0], 1'b0}
                       ^ (signature[SIG_W-1] ? POLY : '0)
                       ^ fold(data);
        end
    end

endmodule

// File: rtl/identity_resp_checker.sv
// rtl/identity_resp_checker.sv - reference vs netlist response checker; MISR under IDENTITY_RESP_MISR_EN
module identity_resp_checker
    import identity_chk_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    identity_resp_checker_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] mis_cnt;
    logic [CNT_W-1:0] mis_nxt;
    logic [CNT_W-1:0] first_idx;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             mismatch;
    logic             last;

    always_comb begin
        mismatch = (bus.y_ref != bus.y_dut);
        last     = (smp_cnt == len_q - 1'b1);
        mis_nxt  = mis_cnt;
        if (mismatch && (mis_cnt != '1)) begin
            mis_nxt = mis_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            smp_cnt   <= '0;
            mis_cnt   <= '0;
            first_idx <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        len_q     <= bus.run_len;
                        smp_cnt   <= '0;
                        mis_cnt   <= '0;
                        first_idx <= '1;
                        if (bus.run_len == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            pass_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.y_valid) begin
                        smp_cnt <= smp_cnt + 1'b1;
                        mis_cnt <= mis_nxt;
                        if (mismatch && (first_idx == '1)) begin
                            first_idx <= smp_cnt;
                        end
                        // Last sample: pass must see this sample's mismatch too
                        if (last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (mis_nxt == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.mismatch_cnt  = mis_cnt;
    assign bus.first_mis_idx = first_idx;

`ifdef IDENTITY_RESP_MISR_EN
    logic             misr_clr;
    logic             misr_en;
    logic [SIG_W-1:0] misr_sig;

    assign misr_clr = bus.start && (state != RUN);
    assign misr_en  = bus.y_valid && (state == RUN);

    identity_misr u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (misr_clr),
        .en        (misr_en),
        .data      (bus.y_ref),
        .signature (misr_sig)
    );

    assign bus.signature = misr_sig;
`else
    assign bus.signature = SEED;
`endif

endmodule

// File: tb/tb_identity_resp_checker.sv
// tb/tb_identity_resp_checker.sv - randomized self-checking bench for identity_resp_checker
module tb_identity_resp_checker;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    identity_resp_checker_if bus();

    identity_resp_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-level model: expected outputs follow from samples accepted so far
    bit          m_running;
    bit          m_finished;
    int          m_len;
    int          m_taken;
    int          m_mis;
    int          m_first;
    logic [31:0] m_sig;

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [126:0] y);
        logic [127:0] e;
        logic [31:0]  f;
        e = {1'b0, y};
        f = e[31:0] ^ e[63:32] ^ e[95:64] ^ e[127:96];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    endfunction

    task automatic model_reset();
        m_running  = 0;
        m_finished = 0;
        m_len      = 0;
        m_taken    = 0;
        m_mis      = 0;
        m_first    = 'hFFFF;
        m_sig      = 32'hFFFF_FFFF;
    endtask

    task automatic model_edge(input bit st, input logic [15:0] len, input bit v,
                              input logic [126:0] r, input logic [126:0] d);
        if (st && !m_running) begin
            m_len      = int'(len);
            m_taken    = 0;
            m_mis      = 0;
            m_first    = 'hFFFF;
            m_sig      = 32'hFFFF_FFFF;
            m_running  = (len != 0);
            m_finished = (len == 0);
        end else if (m_running && v) begin
            if (r != d) begin
                if (m_mis < 'hFFFF) m_mis++;
                if (m_first == 'hFFFF) m_first = m_taken;
            end
            m_sig = misr_step(m_sig, r);
            m_taken++;
            if (m_taken == m_len) begin
                m_running  = 0;
                m_finished = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(m_running));
            chk("done", 64'(bus.done), 64'(m_finished));
            chk("pass", 64'(bus.pass), 64'(m_finished && (m_mis == 0)));
            chk("mismatch_cnt", 64'(bus.mismatch_cnt), 64'(m_mis));
            chk("first_mis_idx", 64'(bus.first_mis_idx), 64'(m_first));
`ifdef IDENTITY_RESP_MISR_EN
            chk("signature", 64'(bus.signature), 64'(m_sig));
`else
            chk("signature", 64'(bus.signature), 64'h0000_0000_FFFF_FFFF);
`endif
        end
    end

    task automatic cycle(input bit st, input logic [15:0] len, input bit v,
                         input logic [126:0] r, input logic [126:0] d);
        bus.start   = st;
        bus.run_len = len;
        bus.y_valid = v;
        bus.y_ref   = r;
        bus.y_dut   = d;
        @(posedge clk);
        model_edge(st, len, v, r, d);
        #1;
    endtask

    function automatic logic [126:0] rnd127();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[126:0];
    endfunction

    function automatic logic [126:0] flip_bit(input logic [126:0] x, input int b);
        logic [126:0] one;
        one = 127'd1;
        return x ^ (one << b);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [126:0] r;
        logic [126:0] d;
        bit           gap_v [7];
        int           cyc;
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 0;
        rst_n   = 1'b0;
        bus.start   = 1'b0;
        bus.run_len = '0;
        bus.y_valid = 1'b0;
        bus.y_ref   = '0;
        bus.y_dut   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_pass", 64'(bus.pass), 64'd0);
        chk("rst_mis", 64'(bus.mismatch_cnt), 64'd0);
        chk("rst_first", 64'(bus.first_mis_idx), 64'hFFFF);
        chk("rst_sig", 64'(bus.signature), 64'hFFFF_FFFF);
        chk("model_misr_pin", 64'(misr_step(32'hFFFF_FFFF, '0)), 64'hFB3E_E249);
        rst_n  = 1'b1;
        chk_en = 1;
        @(posedge clk);
        #1;

        // Matching run
        cycle(1, 16'd8, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            r = rnd127();
            cycle(0, 0, 1, r, r);
            if (i < 7) chk("match_not_done", 64'(bus.done), 64'd0);
        end
        chk("match_done", 64'(bus.done), 64'd1);
        chk("match_pass", 64'(bus.pass), 64'd1);
        chk("match_mis", 64'(bus.mismatch_cnt), 64'd0);
        chk("match_first", 64'(bus.first_mis_idx), 64'hFFFF);

        // Mismatches in bit 126 only
        cycle(1, 16'd10, 0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            r = rnd127();
            d = (i == 3 || i == 7) ? flip_bit(r, 126) : r;
            cycle(0, 0, 1, r, d);
        end
        chk("mis_done", 64'(bus.done), 64'd1);
        chk("mis_cnt", 64'(bus.mismatch_cnt), 64'd2);
        chk("mis_first", 64'(bus.first_mis_idx), 64'd3);
        chk("mis_pass", 64'(bus.pass), 64'd0);

        // Gapped valid with a mismatch on an idle cycle
        gap_v = '{1, 0, 0, 1, 1, 0, 1};
        cycle(1, 16'd4, 0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            r = rnd127();
            d = gap_v[i] ? r : ~r;
            cycle(0, 0, gap_v[i], r, d);
            if (i < 6) chk("gap_not_done", 64'(bus.done), 64'd0);
        end
        chk("gap_done", 64'(bus.done), 64'd1);
        chk("gap_pass", 64'(bus.pass), 64'd1);

        // Zero length, then restart from DONE
        cycle(1, 16'd0, 1, '1, '0);
        chk("zero_done", 64'(bus.done), 64'd1);
        chk("zero_pass", 64'(bus.pass), 64'd1);
        cycle(0, 0, 1, '1, '0);
        chk("zero_hold_mis", 64'(bus.mismatch_cnt), 64'd0);
        cycle(1, 16'd2, 0, '0, '0);
        chk("restart_busy", 64'(bus.busy), 64'd1);
        chk("restart_done", 64'(bus.done), 64'd0);
        chk("restart_mis", 64'(bus.mismatch_cnt), 64'd0);
        r = rnd127();
        cycle(0, 0, 1, r, ~r);
        cycle(1, 16'd5, 1, r, r);
        chk("restart_pass", 64'(bus.pass), 64'd0);

        // MISR single zero sample
        cycle(1, 16'd1, 0, '0, '0);
        cycle(0, 0, 1, '0, '0);
`ifdef IDENTITY_RESP_MISR_EN
        chk("misr_lit", 64'(bus.signature), 64'hFB3E_E249);
`else
        chk("misr_off", 64'(bus.signature), 64'hFFFF_FFFF);
`endif

        // Randomized runs, including ignored starts while running
        for (int run = 0; run < 20; run++) begin
            cycle(1, 16'($urandom_range(30, 0)), 0, '0, '0);
            cyc = 0;
            while (m_running && cyc < 300) begin
                r = rnd127();
                d = ($urandom_range(3, 0) == 0) ? flip_bit(r, $urandom_range(126, 0)) : r;
                cycle(($urandom_range(15, 0) == 0), 16'($urandom_range(20, 0)),
                      ($urandom_range(9, 0) < 7), r, d);
                cyc++;
            end
            chk("rand_finished", 64'(m_running), 64'd0);
            repeat ($urandom_range(3, 0)) begin
                r = rnd127();
                cycle(0, 0, $urandom_range(1, 0), r, ~r);
            end
        end

        // Asynchronous reset in the middle of a run
        cycle(1, 16'd10, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            r = rnd127();
            cycle(0, 0, 1, r, (i == 2) ? ~r : r);
        end
        bus.y_valid = 1'b1;
        bus.y_ref   = rnd127();
        bus.y_dut   = ~bus.y_ref;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_mis", 64'(bus.mismatch_cnt), 64'd0);
        chk("arst_first", 64'(bus.first_mis_idx), 64'hFFFF);
        chk("arst_sig", 64'(bus.signature), 64'hFFFF_FFFF);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(0, 0, 1, bus.y_ref, bus.y_dut);
        #1;
        cycle(0, 0, 1, '1, '0);
        cycle(1, 16'd1, 0, '0, '0);
        r = rnd127();
        cycle(0, 0, 1, r, r);
        chk("post_rst_pass", 64'(bus.pass), 64'd1);

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/identity_resp_checker.md
Name: identity_resp_checker

Overview:
- Hardware-side response checker for identity/equivalence runs: samples two 127-bit response buses each clock, the reference model output and the synthesized-netlist output.
- Compares them cycle by cycle, counts mismatches and records the first mismatching sample index.
- Optionally compacts the reference stream into a MISR signature.
- Sits at the output end of the stimulus/DUT path, consuming the `y` responses that the stimulus driver provokes.

Parameters:
- Y_W, 127, response bus width.
- CNT_W, 16, width of sample-length, mismatch and index counters.
- SIG_W, 32, MISR signature width.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial.
- SEED, 32'hFFFF_FFFF, MISR reset/start value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a run (accepted in IDLE or DONE only).
- run_len  in  CNT_W  number of valid samples in the run; latched on accepted start.
- y_valid  in  1  sample strobe; both buses valid this cycle.
- y_ref  in  Y_W  reference-model response.
- y_dut  in  Y_W  synthesized-netlist response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until next accepted start.
- pass  out  1  in DONE: mismatch_cnt==0; 0 otherwise.
- mismatch_cnt  out  CNT_W  mismatching samples, saturates at all-ones.
- first_mis_idx  out  CNT_W  index of first mismatching sample; all-ones if none.
- signature  out  SIG_W  MISR value (SEED when feature compiled out).

Behaviour:
- Reset value, async on rst_n low:
  - state=IDLE.
  - busy=0, done=0, pass=0.
  - mismatch_cnt=0, first_mis_idx=all-ones, signature=SEED.
  - Internal sample counter=0.
- FSM states and transitions:
  - IDLE: start=1 -> latch run_len, clear counters, set first_mis_idx=all-ones and signature=SEED.
    - Next state is RUN, or DONE directly if run_len==0 (pass=1 in that case).
  - RUN: a cycle with y_valid=1 is one sample; y_valid=0 cycles are ignored.
    - The sample whose index is run_len-1 -> DONE on the next edge.
    - start is ignored in RUN; there is no abort other than rst_n.
  - DONE: done=1, and pass is registered from the final mismatch count.
    - start=1 -> same action as from IDLE (restart); y_valid is ignored.
- Per sample, same edge:
  - mismatch = (y_ref != y_dut), full-width compare.
  - If mismatch: mismatch_cnt += 1, saturating at 2^CNT_W-1.
  - If mismatch and first_mis_idx==all-ones: first_mis_idx <= current sample index.
- Latency:
  - All outputs are registered and update one edge after the sample.
  - done asserts on the edge that consumes the last sample.
- Sample index counts from 0 and equals the number of previously accepted samples.
- run_len==all-ones is legal. Index all-ones on the final sample is indistinguishable from "none"; documented limitation.
- Mid-run reset aborts immediately to reset values; no partial state survives.

Optional Feature:
- Macro IDENTITY_RESP_MISR_EN.
- Defined:
  - y_ref is zero-extended to a multiple of SIG_W and XOR-folded to SIG_W bits (127 -> 128 -> 4 words).
  - On each sample: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ fold.
  - The signature is reset to SEED on accepted start.
- Undefined: the MISR logic is absent and signature is tied to SEED.

Decomposition:
- Package identity_chk_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default widths Y_W/CNT_W/SIG_W and the POLY and SEED constants;
  - the fold function.
- One sub-module, identity_misr: SIG_W register plus fold and shift logic, with ports clk, rst_n, clr, en, data. It is instantiated only under IDENTITY_RESP_MISR_EN.

Test Plan:
- Matching run:
  - Stimulus: run_len=8; 8 valid samples with y_ref==y_dut (random), valid on every cycle.
  - Response: done 1 edge after the 8th sample, pass=1, mismatch_cnt=0, first_mis_idx=16'hFFFF.
- Mismatches:
  - Stimulus: run_len=10; samples 3 and 7 differ in bit 126 only.
  - Response: mismatch_cnt=2, first_mis_idx=3, pass=0.
- Gapped valid:
  - Stimulus: run_len=4; y_valid pattern 1,0,0,1,1,0,1; a mismatch is presented on a y_valid=0 cycle.
  - Response: the gap mismatch is ignored, done after the 7th cycle, pass=1.
- Zero length and restart:
  - Stimulus: start with run_len=0.
  - Response: DONE next edge with pass=1.
  - Stimulus: start again in DONE with run_len=2.
  - Response: busy=1, counters cleared.
- Reset mid-run:
  - Stimulus: rst_n low for 3 ns during sample 5 of 10 (asynchronous, between edges).
  - Response: busy=0, mismatch_cnt=0, first_mis_idx=16'hFFFF, signature=32'hFFFF_FFFF immediately.
- MISR (IDENTITY_RESP_MISR_EN defined):
  - Stimulus: run_len=1 with y_ref=0.
  - Response: signature=32'hFFFF_FFFE^32'h04C1_1DB7=32'hFB3E_E249.
